// File: rtl/adc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_ctrl_pkg
// Description : Shared definitions for the ADC sample controller: default
//               configuration values and the conversion FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_ctrl_pkg;

    localparam int unsigned c_DATA_W_DFLT      = 8;
    localparam int unsigned c_DEPTH_DFLT       = 8;
    localparam int unsigned c_TIMEOUT_CYC_DFLT = 64;

    // Conversion sequence: IDLE -> REQ -> WAIT -> STORE -> IDLE
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_STORE = 2'd3
    } adc_state_t;

endpackage
`default_nettype wire

// File: rtl/adc_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : adc_sample_fifo
// Description : Register-based sample FIFO with zero-latency head output.
//               A push into a full FIFO is accepted only when a pop happens
//               in the same cycle; otherwise it is ignored. Pops on an empty
//               FIFO are ignored. head reads 0 while empty.
// Ports       : clk, rst (async, active-low)
//               push/din  - write request and data
//               pop       - read request (advances head)
//               head      - oldest entry, combinational
//               full/empty/count - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module adc_sample_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned c_AW = $clog2(DEPTH);
    localparam int unsigned c_CW = c_AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    assign empty = (r_count == '0);
    assign full  = (r_count == c_CW'(DEPTH));

    // A pop frees the slot the simultaneous push needs, so full+pop+push works.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointer widths equal log2(DEPTH), so wrap is modulo DEPTH.
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once written.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    assign head  = empty ? '0 : r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/adc_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adc_sample_ctrl
// Description : Periodic ADC sampling controller. A tick timer requests a
//               conversion every max(period,1) cycles while en=1; results are
//               captured and queued in a sample FIFO. Sticky flags record
//               dropped samples, ticks lost while busy, and timeouts.
// Ports       : clk, rst (async, active-low)
//               en, period             - sampling enable and interval
//               adc_req/adc_rdy/adc_dat - ADC handshake
//               pop, sample, valid, count - FIFO consumer side
//               busy                   - conversion in progress
//               overflow/missed/timeout_err, clr_err - sticky error flags
// Config      : ADC_TIMEOUT_EN - when defined, WAIT is bounded to TIMEOUT_CYC
//               cycles; when undefined, WAIT persists and timeout_err = 0.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_sample_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = c_DATA_W_DFLT,
    parameter int unsigned DEPTH       = c_DEPTH_DFLT,
    parameter int unsigned TIMEOUT_CYC = c_TIMEOUT_CYC_DFLT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [15:0]              period,
    output logic                     adc_req,
    input  logic                     adc_rdy,
    input  logic [DATA_W-1:0]        adc_dat,
    input  logic                     pop,
    output logic [DATA_W-1:0]        sample,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     overflow,
    output logic                     missed,
    output logic                     timeout_err,
    input  logic                     clr_err
);

    // Reject configurations the FIFO pointers and timeout counter cannot support.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_cfg_bad
        $error("adc_sample_ctrl: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
    end

    // ------------------------------------------------------------------
    // Tick timer
    // ------------------------------------------------------------------
    logic [15:0] r_timer;
    logic [15:0] w_per_m1;
    logic        w_tick;

    assign w_per_m1 = (period == 16'd0) ? 16'd0 : (period - 16'd1);
    // >= rather than == so a period shrunk mid-count still wraps promptly.
    assign w_tick   = en && (r_timer >= w_per_m1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
        end else if (!en || w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    adc_state_t        r_state;
    logic              r_req;
    logic              r_wait_first;
    logic [DATA_W-1:0] r_cap;
    logic              w_capture;
    logic              w_wait_expired;
    logic              w_timeout_evt;

    // The ADC may still show rdy from a previous conversion during the first
    // WAIT cycle, so capture is only allowed from the second cycle on.
    assign w_capture     = (r_state == ST_WAIT) && !r_wait_first && adc_rdy;
    assign w_timeout_evt = (r_state == ST_WAIT) && !w_capture && w_wait_expired;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_req        <= 1'b0;
            r_wait_first <= 1'b0;
            r_cap        <= '0;
        end else begin
            r_req <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    r_state      <= ST_WAIT;
                    r_wait_first <= 1'b1;
                end
                ST_WAIT: begin
                    r_wait_first <= 1'b0;
                    if (w_capture) begin
                        r_cap   <= adc_dat;
                        r_state <= ST_STORE;
                    end else if (w_timeout_evt) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_STORE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ADC_TIMEOUT_EN
    // Counts WAIT cycles; value k means this is WAIT cycle k+1.
    localparam int unsigned c_TW = $clog2(TIMEOUT_CYC) + 1;
    logic [c_TW-1:0] r_wait_cnt;
    logic            r_timeout;

    assign w_wait_expired = (r_wait_cnt == c_TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
        end else if (r_state != ST_WAIT) begin
            r_wait_cnt <= '0;
        end else if (!w_wait_expired) begin
            r_wait_cnt <= r_wait_cnt + c_TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timeout <= 1'b0;
        end else if (w_timeout_evt) begin
            r_timeout <= 1'b1;
        end else if (clr_err) begin
            r_timeout <= 1'b0;
        end
    end

    assign timeout_err = r_timeout;
`else
    assign w_wait_expired = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    logic w_push;
    logic w_full;
    logic w_empty;
    logic w_drop;

    assign w_push = (r_state == ST_STORE);
    // Sample is lost only when full and no pop frees a slot this cycle.
    assign w_drop = w_push && w_full && !(pop && !w_empty);

    adc_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (r_cap),
        .pop   (pop),
        .head  (sample),
        .full  (w_full),
        .empty (w_empty),
        .count (count)
    );

    // ------------------------------------------------------------------
    // Sticky flags: a set event wins over clr_err in the same cycle
    // ------------------------------------------------------------------
    logic r_overflow;
    logic r_missed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
            r_missed   <= 1'b0;
        end else begin
            if (w_drop)                             r_overflow <= 1'b1;
            else if (clr_err)                       r_overflow <= 1'b0;
            if (w_tick && (r_state != ST_IDLE))     r_missed   <= 1'b1;
            else if (clr_err)                       r_missed   <= 1'b0;
        end
    end

    assign adc_req  = r_req;
    assign busy     = (r_state != ST_IDLE);
    assign valid    = !w_empty;
    assign overflow = r_overflow;
    assign missed   = r_missed;

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_sample_ctrl
// Description : Randomized self-checking bench for adc_sample_ctrl. A
//               timestamp/queue reference model predicts every output each
//               cycle; segments vary period, enable, ADC readiness, pop rate
//               and error clearing, with an asynchronous reset mid-run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_sample_ctrl;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int TO_CYC = 64;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int NSEG   = 14;
    localparam int SEGLEN = 150;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic [15:0]       period = 16'd10;
    logic              adc_req;
    logic              adc_rdy = 1'b0;
    logic [DATA_W-1:0] adc_dat = '0;
    logic              pop = 1'b0;
    logic [DATA_W-1:0] sample;
    logic              valid;
    logic [CW-1:0]     count;
    logic              busy;
    logic              overflow;
    logic              missed;
    logic              timeout_err;
    logic              clr_err = 1'b0;

    adc_sample_ctrl #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .period      (period),
        .adc_req     (adc_req),
        .adc_rdy     (adc_rdy),
        .adc_dat     (adc_dat),
        .pop         (pop),
        .sample      (sample),
        .valid       (valid),
        .count       (count),
        .busy        (busy),
        .overflow    (overflow),
        .missed      (missed),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a conversion is described by its age in cycles since
    // the request went out; the FIFO is a plain queue.
    // ------------------------------------------------------------------
    int                m_timer;
    bit                m_conv;
    bit                m_store;
    int                m_age;
    logic [DATA_W-1:0] m_cap;
    logic [DATA_W-1:0] m_q[$];
    bit                m_ovf, m_miss, m_to;

    function automatic void model_reset();
        m_timer = 0; m_conv = 0; m_store = 0; m_age = 0; m_cap = '0;
        m_q.delete();
        m_ovf = 0; m_miss = 0; m_to = 0;
    endfunction

    function automatic void model_edge();
        int per;
        bit tick, do_pop, drop, to_evt, miss_evt;
        per      = (period == 16'd0) ? 1 : int'(period);
        tick     = en && (m_timer == per - 1);
        m_timer  = (!en || tick) ? 0 : m_timer + 1;
        do_pop   = pop && (m_q.size() > 0);
        drop     = m_store && (m_q.size() == DEPTH) && !do_pop;
        miss_evt = tick && m_conv;
        to_evt   = 0;
        if (do_pop) void'(m_q.pop_front());
        if (m_store && !drop) m_q.push_back(m_cap);
        if (m_conv) begin
            if (m_store) begin
                m_conv = 0; m_store = 0;
            end else begin
                // age 1 is the first WAIT cycle, whose rdy is ignored
                if (m_age >= 2 && adc_rdy) begin
                    m_store = 1; m_cap = adc_dat;
                end
`ifdef ADC_TIMEOUT_EN
                else if (m_age == TO_CYC) begin
                    m_conv = 0; to_evt = 1;
                end
`endif
                m_age++;
            end
        end else if (tick) begin
            m_conv = 1; m_age = 0;
        end
        m_ovf  = drop     ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
        m_miss = miss_evt ? 1'b1 : (clr_err ? 1'b0 : m_miss);
        m_to   = to_evt   ? 1'b1 : (clr_err ? 1'b0 : m_to);
    endfunction

    task automatic compare_all();
        chk("adc_req",     32'(adc_req),     32'(m_conv && !m_store && m_age == 0));
        chk("busy",        32'(busy),        32'(m_conv));
        chk("valid",       32'(valid),       32'(m_q.size() > 0));
        chk("count",       32'(count),       32'(m_q.size()));
        chk("sample",      32'(sample),      (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
        chk("overflow",    32'(overflow),    32'(m_ovf));
        chk("missed",      32'(missed),      32'(m_miss));
        chk("timeout_err", 32'(timeout_err), 32'(m_to));
    endtask

    // Knobs for the current segment (percent probabilities)
    int k_en, k_rdy, k_pop, k_clr;

    task automatic drive_random();
        en      = ($urandom_range(99) < k_en);
        adc_rdy = ($urandom_range(99) < k_rdy);
        pop     = ($urandom_range(99) < k_pop);
        clr_err = ($urandom_range(99) < k_clr);
        adc_dat = DATA_W'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_edge();
        #1;
        compare_all();
    endtask

    int per_t [NSEG] = '{10, 2, 0, 1, 3, 5, 10, 2, 4, 1, 7, 3, 2, 6};
    int en_t  [NSEG] = '{100, 100, 100, 90, 100, 80, 100, 100, 100, 100, 70, 100, 100, 100};
    int rdy_t [NSEG] = '{100, 30, 100, 50, 100, 60, 100, 20, 40, 100, 50, 100, 0, 70};
    int pop_t [NSEG] = '{30, 20, 0, 0, 15, 40, 0, 60, 10, 50, 30, 0, 10, 90};
    int clr_t [NSEG] = '{0, 2, 0, 5, 3, 2, 10, 3, 0, 1, 5, 2, 3, 2};

    initial begin
        model_reset();
        // Reset asserted from time zero: outputs must be at reset values.
        #2;
        compare_all();
        repeat (2) step();
        #2 rst = 1'b1;

        for (int s = 0; s < NSEG; s++) begin
            // Change period only with the timer parked at 0.
            en = 1'b0;
            step();
            period = 16'(per_t[s]);
            k_en = en_t[s]; k_rdy = rdy_t[s]; k_pop = pop_t[s]; k_clr = clr_t[s];
            drive_random();
            for (int c = 0; c < SEGLEN; c++) begin
                step();
                drive_random();
                if (s == 5 && c == 70) begin
                    // Asynchronous reset between clock edges.
                    #2 rst = 1'b0;
                    #1;
                    model_reset();
                    compare_all();
                    repeat (2) step();
                    #2 rst = 1'b1;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_sample_ctrl.md
ADC_SAMPLE_CTRL -- requirements
Module: adc_sample_ctrl

Interface
REQ-001 SHALL have parameters: DATA_W, default 8, ADC sample width; DEPTH, default 8, sample FIFO depth (power of 2); TIMEOUT_CYC, default 64, maximum WAIT cycles.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  periodic sampling enable.
- period  in  16  sample interval in clk cycles (0 treated as 1).
- adc_req  out  1  one-cycle conversion request pulse to the ADC.
- adc_rdy  in  1  ADC conversion-done level.
- adc_dat  in  DATA_W  ADC result, valid while adc_rdy=1.
- pop  in  1  consumer reads the head sample.
- sample  out  DATA_W  FIFO head, valid when valid=1.
- valid  out  1  FIFO not empty.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  a conversion is in progress (state != IDLE).
- overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- missed  out  1  sticky: a tick arrived while busy.
- timeout_err  out  1  sticky: a conversion timed out.
- clr_err  in  1  clears all sticky flags.

Function
REQ-003 SHALL contain a tick timer counting 0..max(period,1)-1 while en=1; a tick fires on the terminal count, then the timer wraps to 0; en=0 holds the timer at 0.
REQ-004 SHALL implement an FSM with states IDLE, REQ, WAIT and STORE.
REQ-005 IDLE->REQ on a tick; REQ drives adc_req=1 for exactly one cycle, then goes to WAIT.
REQ-006 WAIT SHALL ignore adc_rdy in its first cycle; from the second cycle on, the first cycle with adc_rdy=1 captures adc_dat and goes to STORE.
REQ-007 STORE SHALL push the captured value into the FIFO, then return to IDLE; tick-to-FIFO latency is at least 4 cycles.
REQ-008 A tick while state != IDLE SHALL be discarded and SHALL set missed.
REQ-009 en falling during REQ, WAIT or STORE SHALL let the current conversion complete.
REQ-010 Push when full SHALL drop the new sample and set overflow; FIFO contents are unchanged.
REQ-011 Simultaneous pop and push when full SHALL perform both, with no overflow.
REQ-012 Pop when empty SHALL be ignored.
REQ-013 sample/valid/count SHALL reflect FIFO state combinationally from registers, with no read latency; pointers wrap modulo DEPTH.
REQ-014 clr_err SHALL clear the sticky flags; a set event in the same cycle wins.

Reset
REQ-015 rst=0 SHALL asynchronously force: state IDLE, adc_req=0, timer=0, FIFO empty (count=0, valid=0), sample=0, busy=0, and all sticky flags 0.
REQ-016 Reset mid-conversion SHALL abandon the conversion; after release, an adc_rdy from that conversion is ignored because state is IDLE.

Configuration
REQ-017 With ADC_TIMEOUT_EN defined, WAIT exceeding TIMEOUT_CYC cycles SHALL set timeout_err and return to IDLE with no push.
REQ-018 Without ADC_TIMEOUT_EN, WAIT SHALL persist until adc_rdy, no timeout counter SHALL exist, and timeout_err SHALL be tied to 0.

Structure
REQ-019 Package adc_ctrl_pkg SHALL hold the FSM state enum, DATA_W, DEPTH and TIMEOUT_CYC defaults.
REQ-020 The FIFO SHALL be sub-module adc_sample_fifo (push, pop, full, empty, count, head).

Verification
REQ-021 period=10, en=1, ADC returns 0x11,0x22,0x33 -> three adc_req pulses 10 cycles apart; count=3; pops yield 0x11,0x22,0x33, then valid=0.
REQ-022 adc_rdy held high through REQ and the first WAIT cycle, adc_dat=0x5A -> capture occurs on the second WAIT cycle; value 0x5A.
REQ-023 No pops, 9 conversions with DEPTH=8 -> count=8, overflow=1, head is the first sample; clr_err -> overflow=0.
REQ-024 FIFO full, pop and push in the same cycle -> count stays 8, overflow=0, new sample at tail.
REQ-025 period=2, ADC responds after 5 cycles -> missed=1, and no second adc_req while busy.
REQ-026 ADC_TIMEOUT_EN defined, adc_rdy stuck at 0 -> timeout_err=1 after 64 WAIT cycles, back in IDLE, count unchanged; rst=0 mid-WAIT -> adc_req=0 and busy=0 immediately.
